// File: rtl/ram_mult_pkg.sv
// rtl/ram_mult_pkg.sv - shared types and constants for the RAM8 shift-and-add multiplier
// State encoding, default RAM word map and MUL phase length.
package ram_mult_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    MUL  = 3'd3,
    WRLO = 3'd4,
    WRHI = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [2:0] ADDR_A  = 3'd0;
  localparam logic [2:0] ADDR_B  = 3'd1;
  localparam logic [2:0] ADDR_LO = 3'd2;
  localparam logic [2:0] ADDR_HI = 3'd3;

  localparam int MUL_CYCLES = 16;
  localparam int CNT_W      = $clog2(MUL_CYCLES);

endpackage

// File: rtl/shift_add_dp.sv
// rtl/shift_add_dp.sv - shift-and-add datapath: multiplier, multiplicand, accumulator, step counter
// Sequenced by ram_mult_ctrl through load_a / load_b / step strobes.
module shift_add_dp
  import ram_mult_pkg::*;
#(
  parameter int W = 16
) (
  input  logic             i_clk,
  input  logic             i_re,
  input  logic             i_load_a,
  input  logic             i_load_b,
  input  logic             i_step,
  input  logic [W-1:0]     i_din,
  output logic [CNT_W-1:0] o_cnt,
  output logic [2*W-1:0]   o_acc_next
);

  logic [W-1:0]     r_mq;
  logic [W-1:0]     r_md;
  logic [2*W-1:0]   r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   w_addend;
  logic [2*W-1:0]   w_acc_next;

  // Value acc takes at the end of the current MUL step; the FSM needs it to capture the product.
  always_comb begin
    w_addend   = {{W{1'b0}}, r_md} << r_cnt;
    w_acc_next = r_mq[0] ? (r_acc + w_addend) : r_acc;
  end

  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_mq  <= '0;
      r_md  <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_load_a) begin
      r_mq <= i_din;
    end else if (i_load_b) begin
      r_md  <= i_din;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_step) begin
      r_acc <= w_acc_next;
      r_mq  <= r_mq >> 1;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_acc_next = w_acc_next;

endmodule

// File: rtl/ram_mult_ctrl.sv
// rtl/ram_mult_ctrl.sv - fixed-latency multiplier controller driving the RAM8 port
// Reads A and B, multiplies over 16 cycles, writes low/high product words, pulses done.
module ram_mult_ctrl
  import ram_mult_pkg::*;
#(
  parameter int         W       = 16,
  parameter logic [2:0] ADDR_A  = ram_mult_pkg::ADDR_A,
  parameter logic [2:0] ADDR_B  = ram_mult_pkg::ADDR_B,
  parameter logic [2:0] ADDR_LO = ram_mult_pkg::ADDR_LO,
  parameter logic [2:0] ADDR_HI = ram_mult_pkg::ADDR_HI
) (
  input  logic           i_clk,
  input  logic           i_re,
  input  logic           i_start,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*W-1:0] o_product,
  output logic           o_ram_e,
  output logic [2:0]     o_ram_addr,
  output logic           o_ram_w,
  output logic           o_ram_r,
  output logic [W-1:0]   o_ram_din,
  input  logic [W-1:0]   i_ram_dout
);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [2*W-1:0]   r_product;
  logic             r_ram_e;
  logic [2:0]       r_ram_addr;
  logic             r_ram_w;
  logic             r_ram_r;
  logic [W-1:0]     r_ram_din;
  logic [CNT_W-1:0] w_cnt;
  logic [2*W-1:0]   w_acc_next;

  shift_add_dp #(.W(W)) u_dp (
    .i_clk      (i_clk),
    .i_re       (i_re),
    .i_load_a   (r_state == LDA),
    .i_load_b   (r_state == LDB),
    .i_step     (r_state == MUL),
    .i_din      (i_ram_dout),
    .o_cnt      (w_cnt),
    .o_acc_next (w_acc_next)
  );

  // Outputs are registered for the state being entered, so they track the state exactly.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_product  <= '0;
      r_ram_e    <= 1'b0;
      r_ram_addr <= '0;
      r_ram_w    <= 1'b0;
      r_ram_r    <= 1'b0;
      r_ram_din  <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_state    <= LDA;
          r_busy     <= 1'b1;
          r_ram_e    <= 1'b1;
          r_ram_r    <= 1'b1;
          r_ram_addr <= ADDR_A;
        end
        LDA: begin
          r_state    <= LDB;
          r_ram_addr <= ADDR_B;
        end
        LDB: begin
          r_state <= MUL;
          r_ram_e <= 1'b0;
          r_ram_r <= 1'b0;
        end
        MUL: if (w_cnt == CNT_W'(MUL_CYCLES - 1)) begin
          r_state    <= WRLO;
          r_product  <= w_acc_next;
          r_ram_e    <= 1'b1;
          r_ram_w    <= 1'b1;
          r_ram_addr <= ADDR_LO;
          r_ram_din  <= w_acc_next[W-1:0];
        end
        WRLO: begin
          r_state    <= WRHI;
          r_ram_addr <= ADDR_HI;
          r_ram_din  <= r_product[2*W-1:W];
        end
        WRHI: begin
          r_state <= DONE;
          r_ram_e <= 1'b0;
          r_ram_w <= 1'b0;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_product  = r_product;
  assign o_ram_e    = r_ram_e;
  assign o_ram_addr = r_ram_addr;
  assign o_ram_w    = r_ram_w;
  assign o_ram_r    = r_ram_r;
  assign o_ram_din  = r_ram_din;

endmodule

// File: tb/tb_ram_mult_ctrl.sv
// tb/tb_ram_mult_ctrl.sv - self-checking bench for ram_mult_ctrl with a behavioural RAM8
// Vector table of operand pairs, then reset-abort and held-start sequences.
module tb_ram_mult_ctrl;

  logic        clk = 1'b0;
  logic        re = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        ram_e;
  logic [2:0]  ram_addr;
  logic        ram_w;
  logic        ram_r;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  logic [15:0] ram [8];
  int          n_writes = 0;
  int          n_bad_writes = 0;
  int          n_reads = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  ram_mult_ctrl dut (
    .i_clk      (clk),
    .i_re       (re),
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_product  (product),
    .o_ram_e    (ram_e),
    .o_ram_addr (ram_addr),
    .o_ram_w    (ram_w),
    .o_ram_r    (ram_r),
    .o_ram_din  (ram_din),
    .i_ram_dout (ram_dout)
  );

  assign ram_dout = ram[ram_addr];

  always @(posedge clk) begin
    if (ram_w) begin
      n_writes++;
      if (!ram_e || (ram_addr != 3'd2 && ram_addr != 3'd3)) n_bad_writes++;
      if (ram_e) ram[ram_addr] = ram_din;
    end
    if (ram_e && ram_r) n_reads++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulses start for one edge, then walks cycles 1.. until done or a 40-cycle bound.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output int done_cyc, output logic [31:0] prod, output logic busy1);
    int cyc;
    ram[0] = a;
    ram[1] = b;
    ram[2] = 16'h5555;
    ram[3] = 16'h5555;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy1 = busy;
    done_cyc = -1;
    prod = 'x;
    while (cyc < 40 && done_cyc < 0) begin
      if (done) begin
        done_cyc = cyc;
        prod = product;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          dc;
    logic [31:0] pr;
    logic        b1;
    int          done_cycles[$];
    logic [31:0] done_prods[$];
    logic        busy_gap;
    int          cyc;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{16'h0000, 16'h1234, 32'h0000_0000};
    vecs[3] = '{16'h1234, 16'h0010, 32'h0001_2340};
    vecs[4] = '{16'h8000, 16'h0002, 32'h0001_0000};
    vecs[5] = '{16'hABCD, 16'h0001, 32'h0000_ABCD};
    vecs[6] = '{16'h00FF, 16'h0101, 32'h0000_FFFF};

    for (int i = 0; i < 8; i++) ram[i] = 16'h0000;

    re = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_product", product, 32'd0);
    chk("reset_ram_ctl", {29'd0, ram_e, ram_w, ram_r}, 32'd0);
    chk("reset_ram_addr", {29'd0, ram_addr}, 32'd0);
    chk("reset_ram_din", {16'd0, ram_din}, 32'd0);
    re = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, dc, pr, b1);
      chk($sformatf("v%0d_busy_cycle1", i), {31'd0, b1}, 32'd1);
      chk($sformatf("v%0d_done_cycle", i), dc, 32'd21);
      chk($sformatf("v%0d_product", i), pr, vecs[i].prod);
      chk($sformatf("v%0d_ram2", i), {16'd0, ram[2]}, {16'd0, vecs[i].prod[15:0]});
      chk($sformatf("v%0d_ram3", i), {16'd0, ram[3]}, {16'd0, vecs[i].prod[31:16]});
      chk($sformatf("v%0d_ram0_kept", i), {16'd0, ram[0]}, {16'd0, vecs[i].a});
      @(negedge clk);
      chk($sformatf("v%0d_idle_cycle22", i), {30'd0, busy, done}, 32'd0);
      chk($sformatf("v%0d_product_hold", i), product, vecs[i].prod);
    end
    chk("writes_total", n_writes, 32'd14);
    chk("reads_total", n_reads, 32'd14);

    // Reset during MUL must abort with no RAM write.
    n_writes = 0;
    ram[0] = 16'h0102;
    ram[1] = 16'h0304;
    ram[2] = 16'hAAAA;
    ram[3] = 16'hAAAA;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_product", product, 32'd0);
    chk("abort_ram_ctl", {29'd0, ram_e, ram_w, ram_r}, 32'd0);
    repeat (25) begin
      @(negedge clk);
      if (busy || done) break;
    end
    chk("abort_stays_idle", {30'd0, busy, done}, 32'd0);
    chk("abort_ram2", {16'd0, ram[2]}, 32'h0000_AAAA);
    chk("abort_ram3", {16'd0, ram[3]}, 32'h0000_AAAA);
    chk("abort_no_write", n_writes, 32'd0);

    // start held for 60 cycles: operations back to back, start ignored while busy.
    n_reads = 0;
    ram[0] = 16'd7;
    ram[1] = 16'd9;
    busy_gap = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_cycles.push_back(cyc);
        done_prods.push_back(product);
      end
      if (cyc <= 43 && cyc != 22 && !busy) busy_gap = 1'b1;
    end
    start = 1'b0;
    chk("held_done_count", done_cycles.size(), 32'd2);
    if (done_cycles.size() == 2) begin
      chk("held_done1_cycle", done_cycles[0], 32'd21);
      chk("held_done2_cycle", done_cycles[1], 32'd43);
      chk("held_product1", done_prods[0], 32'd63);
      chk("held_product2", done_prods[1], 32'd63);
    end
    chk("held_busy_continuous", {31'd0, busy_gap}, 32'd0);
    chk("held_reads", n_reads, 32'd6);
    cyc = 0;
    while (busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("held_drains_idle", {31'd0, busy}, 32'd0);
    chk("held_ram2", {16'd0, ram[2]}, 32'd63);
    chk("bad_writes", n_bad_writes, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
